pmp_frame_ctrl: RTL and testbench

//  Stack-frame bound controller for physical memory protection. Tracks nested interrupt

---
 rtl/pmp_frame_ctrl_if.sv | 22 ++
 rtl/pmp_frame_ctrl.sv | 131 +++++++++++++
 tb/tb_pmp_frame_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pmp_frame_ctrl_if.sv
// Memory-access and fault-handshake bundle between the core/N-CLIC side and pmp_frame_ctrl.
// The master drives accesses and acknowledges faults; the slave checks and raises them.
interface pmp_frame_ctrl_if #(
  parameter int AddrWidth = 16
);
  logic                 mem_valid;
  logic [AddrWidth-1:0] mem_addr;
  logic                 fault_ack;
  logic                 fault_req;
  logic [AddrWidth-1:0] fault_addr;
  logic                 fault_lost;

  modport master (
    output mem_valid, mem_addr, fault_ack,
    input  fault_req, fault_addr, fault_lost
  );

  modport slave (
    input  mem_valid, mem_addr, fault_ack,
    output fault_req, fault_addr, fault_lost
  );
endinterface

// File: rtl/pmp_frame_ctrl.sv
// Stack-frame bound controller: LIFO of per-interrupt-level stack end pointers, window check
// of every load/store against [sp, ep] or a CSR grant window, and a held fault request.
module pmp_frame_ctrl #(
  parameter int                   AddrWidth = 16,
  parameter int                   Depth     = 8,
  parameter logic [AddrWidth-1:0] StackTop  = '1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         irq_entry,
  input  logic                         irq_exit,
  input  logic [AddrWidth-1:0]         sp,
  input  logic                         grant_en,
  input  logic [AddrWidth-1:0]         grant_lo,
  input  logic [AddrWidth-1:0]         grant_hi,
  pmp_frame_ctrl_if.slave              bus,
  output logic [AddrWidth-1:0]         ep_out,
  output logic [$clog2(Depth+1)-1:0]   depth_out,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int DepthW = $clog2(Depth + 1);
  localparam int IdxW   = (Depth > 1) ? $clog2(Depth) : 1;

  typedef enum logic {
    IDLE,
    FAULT
  } state_e;

  logic [AddrWidth-1:0] frame_q [Depth];
  logic [AddrWidth-1:0] frame_d [Depth];
  logic [DepthW-1:0]    depth_q,      depth_d;
  logic                 overflow_q,   overflow_d;
  logic                 underflow_q,  underflow_d;
  state_e               state_q,      state_d;
  logic [AddrWidth-1:0] fault_addr_q, fault_addr_d;
  logic                 fault_lost_q, fault_lost_d;

  logic                 in_frame;
  logic                 in_grant;
  logic                 viol;

  // Active frame end is always derived from registered state, so it moves the cycle after entry/exit.
  always_comb begin
    ep_out = StackTop;
    if (depth_q != '0) ep_out = frame_q[IdxW'(depth_q - 1'b1)];
  end

  // Frame LIFO next-state.
  always_comb begin
    frame_d     = frame_q;
    depth_d     = depth_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    unique case ({irq_entry, irq_exit})
      2'b10: begin
        if (depth_q < DepthW'(Depth)) begin
          frame_d[IdxW'(depth_q)] = sp;
          depth_d                 = depth_q + 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
      2'b01: begin
        if (depth_q != '0) depth_d     = depth_q - 1'b1;
        else               underflow_d = 1'b1;
      end
      2'b11: begin
        if (depth_q != '0) frame_d[IdxW'(depth_q - 1'b1)] = sp;
      end
      default: ;
    endcase
  end

  assign in_frame = (sp <= bus.mem_addr) && (bus.mem_addr <= ep_out);
  assign in_grant = grant_en && (grant_lo <= bus.mem_addr) && (bus.mem_addr <= grant_hi);
  assign viol     = enable && bus.mem_valid && !(in_frame || in_grant);

  always_comb begin
    state_d      = state_q;
    fault_addr_d = fault_addr_q;
    fault_lost_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (viol) begin
          state_d      = FAULT;
          fault_addr_d = bus.mem_addr;
        end
      end
      FAULT: begin
        // A second violation is reported as lost, never re-captured, even on the ack cycle.
        fault_lost_d = viol;
        if (bus.fault_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q      <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      state_q      <= IDLE;
      fault_addr_q <= '0;
      fault_lost_q <= 1'b0;
    end else begin
      depth_q      <= depth_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      state_q      <= state_d;
      fault_addr_q <= fault_addr_d;
      fault_lost_q <= fault_lost_d;
    end
  end

  // NOTE: frame storage is deliberately left unreset; entries above depth_q are never read.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  assign depth_out      = depth_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;
  assign bus.fault_req  = (state_q == FAULT);
  assign bus.fault_addr = fault_addr_q;
  assign bus.fault_lost = fault_lost_q;

endmodule

// File: tb/tb_pmp_frame_ctrl.sv
// Self-checking bench for pmp_frame_ctrl: directed scenarios plus randomized traffic,
// compared each cycle against a queue-based reference model of the frame stack and fault state.
module tb_pmp_frame_ctrl;

  localparam int          AW    = 16;
  localparam int          DEPTH = 8;
  localparam logic [15:0] TOP   = 16'hFFFF;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          irq_entry;
  logic          irq_exit;
  logic [AW-1:0] sp;
  logic          grant_en;
  logic [AW-1:0] grant_lo;
  logic [AW-1:0] grant_hi;
  logic [AW-1:0] ep_out;
  logic [3:0]    depth_out;
  logic          overflow;
  logic          underflow;

  pmp_frame_ctrl_if #(.AddrWidth(AW)) bus ();

  pmp_frame_ctrl #(.AddrWidth(AW), .Depth(DEPTH), .StackTop(TOP)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .irq_entry (irq_entry),
    .irq_exit  (irq_exit),
    .sp        (sp),
    .grant_en  (grant_en),
    .grant_lo  (grant_lo),
    .grant_hi  (grant_hi),
    .bus       (bus.slave),
    .ep_out    (ep_out),
    .depth_out (depth_out),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the frame stack is a plain queue whose size is the nesting depth.
  logic [15:0] m_stack [$];
  bit          m_pend;
  logic [15:0] m_faddr;
  bit          m_lost;
  bit          m_ovf;
  bit          m_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_all();
    logic [15:0] m_ep;
    m_ep = (m_stack.size() == 0) ? TOP : m_stack[m_stack.size()-1];
    check("depth_out",  32'(depth_out),      32'(m_stack.size()));
    check("ep_out",     32'(ep_out),         32'(m_ep));
    check("fault_req",  32'(bus.fault_req),  32'(m_pend));
    check("fault_addr", 32'(bus.fault_addr), 32'(m_faddr));
    check("fault_lost", 32'(bus.fault_lost), 32'(m_lost));
    check("overflow",   32'(overflow),       32'(m_ovf));
    check("underflow",  32'(underflow),      32'(m_unf));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare every output.
  task automatic apply(input bit rst, input bit en, input bit ent, input bit ext,
                       input logic [15:0] s, input bit v, input logic [15:0] a,
                       input bit ge, input logic [15:0] lo, input logic [15:0] hi,
                       input bit ack);
    logic [15:0] ep;
    bit          ok;
    bit          viol;
    reset         = rst;
    enable        = en;
    irq_entry     = ent;
    irq_exit      = ext;
    sp            = s;
    bus.mem_valid = v;
    bus.mem_addr  = a;
    grant_en      = ge;
    grant_lo      = lo;
    grant_hi      = hi;
    bus.fault_ack = ack;

    if (rst) begin
      m_stack.delete();
      m_pend  = 1'b0;
      m_faddr = '0;
      m_lost  = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      ep   = (m_stack.size() == 0) ? TOP : m_stack[m_stack.size()-1];
      ok   = (s <= a && a <= ep) || (ge && lo <= a && a <= hi);
      viol = en && v && !ok;
      m_lost = 1'b0;
      if (!m_pend) begin
        if (viol) begin
          m_pend  = 1'b1;
          m_faddr = a;
        end
      end else begin
        m_lost = viol;
        if (ack) m_pend = 1'b0;
      end
      if (ent && !ext) begin
        if (m_stack.size() < DEPTH) m_stack.push_back(s);
        else                        m_ovf = 1'b1;
      end else if (ext && !ent) begin
        if (m_stack.size() > 0) void'(m_stack.pop_back());
        else                    m_unf = 1'b1;
      end else if (ent && ext) begin
        if (m_stack.size() > 0) m_stack[m_stack.size()-1] = s;
      end
    end

    @(posedge clk);
    #1;
    check_all();
  endtask

  // Shorthands: plain access, interrupt event, quiet cycle.
  task automatic access(input logic [15:0] s, input logic [15:0] a, input bit ack);
    apply(0, 1, 0, 0, s, 1, a, 0, 16'h0, 16'h0, ack);
  endtask

  task automatic irq(input bit ent, input bit ext, input logic [15:0] s);
    apply(0, 1, ent, ext, s, 0, 16'h0, 0, 16'h0, 16'h0, 0);
  endtask

  initial begin
    // Reset state
    apply(1, 0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0, 0);
    apply(1, 0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0, 0);
    check("rst_ep", 32'(ep_out), 32'h0000_FFFF);
    check("rst_depth", 32'(depth_out), 32'd0);

    // Depth 0: window is [sp, StackTop]
    access(16'h1000, 16'h2000, 0);
    check("d0_no_fault", 32'(bus.fault_req), 32'd0);

    // Enter a handler, then probe the new frame's bounds and an over-the-end access
    irq(1, 0, 16'h8000);
    check("entry_ep", 32'(ep_out), 32'h8000);
    access(16'h7F00, 16'h7F00, 0);
    access(16'h7F00, 16'h8000, 0);
    check("bounds_ok", 32'(bus.fault_req), 32'd0);
    access(16'h7F00, 16'h8100, 0);
    check("fault_set", 32'(bus.fault_req), 32'd1);
    check("fault_addr", 32'(bus.fault_addr), 32'h8100);

    // Second violation while pending is lost, capture unchanged; then acknowledge
    access(16'h7F00, 16'h9000, 0);
    check("lost_pulse", 32'(bus.fault_lost), 32'd1);
    check("addr_held", 32'(bus.fault_addr), 32'h8100);
    apply(0, 1, 0, 0, 16'h7F00, 0, 16'h0, 0, 16'h0, 16'h0, 1);
    check("ack_clear", 32'(bus.fault_req), 32'd0);
    check("lost_one_cycle", 32'(bus.fault_lost), 32'd0);

    // Grant window, inclusive high bound
    apply(0, 1, 0, 0, 16'h7F00, 1, 16'h90FF, 1, 16'h9000, 16'h90FF, 0);
    check("grant_hi_ok", 32'(bus.fault_req), 32'd0);
    apply(0, 1, 0, 0, 16'h7F00, 1, 16'h9100, 1, 16'h9000, 16'h90FF, 0);
    check("grant_out", 32'(bus.fault_req), 32'd1);

    // Reset while a fault is pending drops it
    apply(1, 1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0, 0);
    check("rst_in_fault", 32'(bus.fault_req), 32'd0);

    // Nesting limits
    for (int i = 0; i < DEPTH + 1; i++) irq(1, 0, 16'hF000 - 16'(i * 16'h100));
    check("ovf_depth", 32'(depth_out), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH + 1; i++) irq(0, 1, 16'h0);
    check("unf_depth", 32'(depth_out), 32'd0);
    check("unf_flag", 32'(underflow), 32'd1);
    check("unf_ep", 32'(ep_out), 32'h0000_FFFF);

    // Simultaneous entry and exit replaces the top frame
    irq(1, 0, 16'hA000);
    irq(1, 0, 16'h9000);
    irq(1, 0, 16'h8000);
    irq(1, 1, 16'h5555);
    check("swap_depth", 32'(depth_out), 32'd3);
    check("swap_ep", 32'(ep_out), 32'h5555);

    // Checking disabled: out-of-window access raises nothing
    apply(0, 0, 0, 0, 16'h5000, 1, 16'h6000, 0, 16'h0, 16'h0, 0);
    check("disabled", 32'(bus.fault_req), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [15:0] r_sp;
      logic [15:0] r_lo;
      r_sp = 16'h7800 + 16'($urandom_range(0, 16'h1000));
      r_lo = 16'h7000 + 16'($urandom_range(0, 16'h2000));
      apply(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            r_sp,
            ($urandom_range(0, 1) == 1),
            16'h7000 + 16'($urandom_range(0, 16'h2000)),
            ($urandom_range(0, 2) == 0),
            r_lo,
            r_lo + 16'($urandom_range(0, 16'h200)),
            ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
